fetch_prefetch_buffer: RTL and testbench
========================================

Name: fetch_prefetch_buffer

Overview:
Instruction-fetch stage between the synchronous instruction memory and the MJ32 core. It generates sequential fetch addresses and issues reads to instruction memory, which has a one-cycle read latency. Returned words are buffered with their PCs in a first-word-fall-through FIFO and presented to the core over a valid/ready handshake. A redirect on `preset`/`preset_address` flushes the buffer and any in-flight read, then restarts fetch at the new address.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  fetch enable; when low, no new memory requests are issued.
- preset  input  1  redirect strobe from the core.
- preset_address  input  32  redirect target; bits [1:0] are ignored.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  32  read address; equals fetch_pc.
- imem_data  input  32  read data, valid in the cycle after imem_req.
- out_valid  output  1  the head entry is valid.
- out_ready  input  1  the core accepts the head entry.
- out_instruction  output  32  head instruction word.
- out_pc  output  32  address of the head instruction.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous) sets:
  - fetch_pc = RESET_PC;
  - rd_ptr = wr_ptr = 0, fifo_count = 0;
  - inflight = 0, req_pc = 0;
  - imem_req = 0, out_valid = 0, out_instruction = 0, out_pc = 0.
- Reset asserted mid-operation discards all buffered and in-flight data. After deassertion, fetch restarts at RESET_PC.
- Issue condition: imem_req = enable && !preset && (fifo_count + inflight < DEPTH). This is combinational from registered state plus `enable` and `preset`.
- On an issue edge:
  - req_pc <= fetch_pc;
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0);
  - inflight <= 1.
- With no issue, inflight <= 0.
- Response: when inflight = 1 and no preset this cycle, {imem_data, req_pc} is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Latency: a request issued in cycle N returns data in N+1, and out_valid is high in N+2. Sustained throughput is one instruction per cycle when out_ready is held high.
- Output is first-word-fall-through:
  - out_valid = (fifo_count != 0);
  - out_instruction and out_pc show the entry at rd_ptr;
  - both are driven 0 when the FIFO is empty.
- Pop occurs when out_valid && out_ready; rd_ptr then increments modulo DEPTH.
- Simultaneous push and pop leaves fifo_count unchanged.
- The credit rule makes push-at-full impossible; pop-at-empty is impossible by definition.
- Redirect (preset = 1), which has priority over all else:
  - fifo_count <= 0, rd_ptr <= wr_ptr;
  - a response arriving in the preset cycle is dropped;
  - inflight <= 0;
  - fetch_pc <= {preset_address[31:2], 2'b00};
  - imem_req = 0 in the preset cycle;
  - a pop in the preset cycle is ignored.
- After a redirect, the first request is issued the next cycle (if enabled) and its out_valid appears 2 cycles after that.
- Back-to-back presets: the last one wins, and no requests are issued while preset is held.
- enable low: no new issues. An already in-flight response is still written, and pops continue. Fetch resumes from the current fetch_pc when enable rises.
- out_ready low with the FIFO full: issue stalls, contents hold, and out_instruction and out_pc remain stable.

Test Plan:
1. Reset → enable=1 with out_ready=1, memory holding word k at address 4k.
   - Required: out_valid rises 2 cycles after the first imem_req.
   - Required: the core then sees out_pc 0, 4, 8, … on consecutive cycles with matching words.
2. out_ready=0 for 10 cycles.
   - Required: fifo_count saturates at DEPTH=4 and imem_req stays 0 once count + inflight = 4.
   - Required: the head stays out_pc=0.
   - Then out_ready=1 → PCs 0, 4, 8, 12, 16 in order with no gaps or duplicates.
3. preset=1, preset_address=32'h0000_0103 asserted while 3 entries are buffered and one read is in flight.
   - Required: out_valid=0 the next cycle and the in-flight word is never delivered.
   - Required: the next imem_addr is 32'h100 and the next delivered out_pc is 32'h100.
4. RESET_PC=32'hFFFF_FFF8 with out_ready=1.
   - Required: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
5. Drop enable the cycle after an issue.
   - Required: that response is still buffered and no further imem_req occurs.
   - On re-enable, fetch continues at the next sequential PC.
6. Assert reset asynchronously mid-stream, between clock edges.
   - Required: out_valid, imem_req and fifo_count go to 0 immediately.
   - Required: after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch stage: issues sequential reads to a one-cycle-latency
// instruction memory and buffers {word, pc} pairs in a first-word-fall-through FIFO.
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     preset,
    input  logic [31:0]              preset_address,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instruction,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] credits_used;

    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;

    // Handshake: the head entry transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and the
    // head word/pc stay stable while out_valid is high and out_ready is low.

    // A request is only issued when a FIFO slot is guaranteed for its response,
    // counting the one read that may already be in flight.
    always_comb begin
        credits_used = count + {{AW{1'b0}}, inflight};
        issue        = enable && !preset && !reset && (credits_used < DEPTH_C);
        push         = inflight && !preset;
        pop          = out_valid && out_ready && !preset;
    end

    always_comb begin
        imem_req        = issue;
        imem_addr       = fetch_pc;
        fifo_count      = count;
        out_valid       = (count != '0);
        out_instruction = '0;
        out_pc          = '0;
        if (out_valid) begin
            out_instruction = buf_instr[rd_ptr];
            out_pc          = buf_pc[rd_ptr];
        end
    end

    // Redirect wins over everything: buffered entries, the in-flight response
    // and any pop in the same cycle are all discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (preset) begin
            fetch_pc <= {preset_address[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= wr_ptr;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count/rd_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed self-checking bench for fetch_prefetch_buffer: streaming, back-pressure,
// redirect, PC wrap, enable gating and asynchronous reset.
module tb_fetch_prefetch_buffer;

    logic        clk;
    logic        reset;

    logic        enable;
    logic        preset;
    logic [31:0] preset_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [2:0]  fifo_count;

    logic        enable_hi;
    logic        preset_hi;
    logic [31:0] preset_address_hi;
    logic        imem_req_hi;
    logic [31:0] imem_addr_hi;
    logic [31:0] imem_data_hi;
    logic        out_valid_hi;
    logic        out_ready_hi;
    logic [31:0] out_instruction_hi;
    logic [31:0] out_pc_hi;
    logic [2:0]  fifo_count_hi;

    int n_compared;
    int n_mismatched;

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .preset          (preset),
        .preset_address  (preset_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .fifo_count      (fifo_count)
    );

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable_hi),
        .preset          (preset_hi),
        .preset_address  (preset_address_hi),
        .imem_req        (imem_req_hi),
        .imem_addr       (imem_addr_hi),
        .imem_data       (imem_data_hi),
        .out_valid       (out_valid_hi),
        .out_ready       (out_ready_hi),
        .out_instruction (out_instruction_hi),
        .out_pc          (out_pc_hi),
        .fifo_count      (fifo_count_hi)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_compared);
        $fatal(1, "watchdog");
    end

    // memory holds word k at address 4k, tagged so words differ from pcs
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ (addr >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_data <= mem_word(imem_addr);
        if (imem_req_hi) imem_data_hi <= mem_word(imem_addr_hi);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        preset    = 1'b0;
        out_ready = 1'b0;
        enable_hi = 1'b0;
        tick();
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instruction, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] hi_pcs [4];
        n_compared        = 0;
        n_mismatched      = 0;
        preset_address    = 32'd0;
        preset_hi         = 1'b0;
        preset_address_hi = 32'd0;
        out_ready_hi      = 1'b1;
        enable_hi         = 1'b0;

        // streaming with out_ready high
        apply_reset();
        check("t1_addr_reset", imem_addr, 32'd0);
        enable    = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t1_req_c0", {31'd0, imem_req}, 32'd1);
        check("t1_addr_c0", imem_addr, 32'd0);
        tick(); #1;
        check("t1_valid_c1", {31'd0, out_valid}, 32'd0);
        check("t1_addr_c1", imem_addr, 32'd4);
        tick(); #1;
        for (int i = 0; i < 6; i++) begin
            check("t1_valid", {31'd0, out_valid}, 32'd1);
            check("t1_pc", out_pc, 32'(4 * i));
            check("t1_instr", out_instruction, mem_word(32'(4 * i)));
            tick(); #1;
        end

        // asynchronous reset between edges, then restart at RESET_PC
        #3;
        reset = 1'b1;
        #1;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_count", {29'd0, fifo_count}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("t6_req_c0", {31'd0, imem_req}, 32'd1);
        check("t6_addr_c0", imem_addr, 32'd0);
        tick(); tick(); #1;
        check("t6_valid_c2", {31'd0, out_valid}, 32'd1);
        check("t6_pc_c2", out_pc, 32'd0);

        // back-pressure: fill to DEPTH, then drain in order
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("t2_req", {31'd0, imem_req}, (c < 4) ? 32'd1 : 32'd0);
            check("t2_count", {29'd0, fifo_count}, (c < 2) ? 32'd0 : ((c - 1 > 4) ? 32'd4 : 32'(c - 1)));
            if (c >= 2) check("t2_head", out_pc, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("t2_valid", {31'd0, out_valid}, 32'd1);
            check("t2_pc", out_pc, 32'(4 * j));
            check("t2_instr", out_instruction, mem_word(32'(4 * j)));
            tick();
        end

        // redirect with 3 buffered entries and one read in flight
        apply_reset();
        enable = 1'b1;
        #1;
        repeat (4) tick();
        #1;
        check("t3_count_pre", {29'd0, fifo_count}, 32'd3);
        preset         = 1'b1;
        preset_address = 32'h0000_0103;
        out_ready      = 1'b1;
        #1;
        check("t3_req_preset", {31'd0, imem_req}, 32'd0);
        tick();
        preset = 1'b0;
        #1;
        check("t3_valid_c5", {31'd0, out_valid}, 32'd0);
        check("t3_count_c5", {29'd0, fifo_count}, 32'd0);
        check("t3_req_c5", {31'd0, imem_req}, 32'd1);
        check("t3_addr_c5", imem_addr, 32'h100);
        tick(); #1;
        check("t3_valid_c6", {31'd0, out_valid}, 32'd0);
        check("t3_addr_c6", imem_addr, 32'h104);
        tick(); #1;
        check("t3_valid_c7", {31'd0, out_valid}, 32'd1);
        check("t3_pc_c7", out_pc, 32'h100);
        check("t3_instr_c7", out_instruction, mem_word(32'h100));
        tick(); #1;
        check("t3_pc_c8", out_pc, 32'h104);
        // back-to-back redirects: last one wins, no issue while held
        tick();
        preset         = 1'b1;
        preset_address = 32'h0000_0200;
        #1;
        check("t3_req_hold1", {31'd0, imem_req}, 32'd0);
        tick();
        preset_address = 32'h0000_0303;
        #1;
        check("t3_req_hold2", {31'd0, imem_req}, 32'd0);
        check("t3_valid_hold2", {31'd0, out_valid}, 32'd0);
        tick();
        preset = 1'b0;
        #1;
        check("t3_addr_last", imem_addr, 32'h300);
        check("t3_req_last", {31'd0, imem_req}, 32'd1);
        tick(); tick(); #1;
        check("t3_pc_last", out_pc, 32'h300);

        // enable dropped the cycle after an issue
        apply_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t5_req_c0", {31'd0, imem_req}, 32'd1);
        tick();
        enable = 1'b0;
        #1;
        check("t5_req_c1", {31'd0, imem_req}, 32'd0);
        tick(); #1;
        check("t5_valid_c2", {31'd0, out_valid}, 32'd1);
        check("t5_pc_c2", out_pc, 32'd0);
        check("t5_req_c2", {31'd0, imem_req}, 32'd0);
        tick(); #1;
        check("t5_valid_c3", {31'd0, out_valid}, 32'd0);
        check("t5_req_c3", {31'd0, imem_req}, 32'd0);
        check("t5_addr_c3", imem_addr, 32'd4);
        tick(); #1;
        check("t5_req_c4", {31'd0, imem_req}, 32'd0);
        tick();
        enable = 1'b1;
        #1;
        check("t5_req_c5", {31'd0, imem_req}, 32'd1);
        check("t5_addr_c5", imem_addr, 32'd4);
        tick(); tick(); #1;
        check("t5_pc_c7", out_pc, 32'd4);
        check("t5_instr_c7", out_instruction, mem_word(32'd4));

        // PC wrap from RESET_PC = FFFF_FFF8
        apply_reset();
        enable_hi = 1'b1;
        hi_pcs[0] = 32'hFFFF_FFF8;
        hi_pcs[1] = 32'hFFFF_FFFC;
        hi_pcs[2] = 32'h0000_0000;
        hi_pcs[3] = 32'h0000_0004;
        #1;
        check("t4_req_c0", {31'd0, imem_req_hi}, 32'd1);
        check("t4_addr_c0", imem_addr_hi, 32'hFFFF_FFF8);
        tick(); tick(); #1;
        check("t4_addr_c2", imem_addr_hi, 32'h0000_0000);
        for (int k = 0; k < 4; k++) begin
            check("t4_valid", {31'd0, out_valid_hi}, 32'd1);
            check("t4_pc", out_pc_hi, hi_pcs[k]);
            check("t4_instr", out_instruction_hi, mem_word(hi_pcs[k]));
            tick(); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
